// File: rtl/axis_packetizer_pkg.sv
// ---------------------------------------------------------------------------
// axis_packetizer_pkg
// Shared types and constants for the AXI-Stream packetizer.
//   state_t    : framing FSM encoding (IDLE=0, BODY=1)
//   PKT_CNT_W  : width of the completed-packet counter
// ---------------------------------------------------------------------------
package axis_packetizer_pkg;

  typedef enum logic {
    IDLE = 1'b0,  // no beat of the current packet has been sent yet
    BODY = 1'b1   // at least one beat of the current packet has been sent
  } state_t;

  localparam int PKT_CNT_W = 16;

endpackage

// File: rtl/axis_sync_fifo.sv
// ---------------------------------------------------------------------------
// axis_sync_fifo
// Single-clock FIFO, power-of-two depth, first-word-fall-through read port.
// Ports:
//   i_clk, i_rst_n      : clock, asynchronous active-low reset
//   i_wr_en, i_wr_data  : write request and entry (ignored while full)
//   i_rd_en             : pop the head entry (ignored while empty)
//   o_rd_data           : head entry, valid whenever o_empty is low
//   o_full, o_empty     : occupancy flags
// ---------------------------------------------------------------------------
module axis_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  // One bit wider than the pointers so that full and empty are distinct.
  logic [AW:0]      r_count;

  logic w_do_wr;
  logic w_do_rd;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_rd_data = r_mem[r_rd_ptr];

  // A write while full is dropped even if a pop happens in the same cycle.
  assign w_do_wr = i_wr_en & ~o_full;
  assign w_do_rd = i_rd_en & ~o_empty;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: reads are only meaningful while non-empty.
  always_ff @(posedge i_clk) begin
    if (w_do_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

endmodule

// File: rtl/axis_packetizer.sv
// ---------------------------------------------------------------------------
// axis_packetizer
// Buffers an AXI-Stream and frames it into packets of PKT_LEN beats, or
// shorter when a beat arrives with flush set. Beats with all strobes low are
// consumed and dropped.
// Ports:
//   s01_axis_aclk/aresetn : clock, asynchronous active-low reset
//   s01_axis_t*           : upstream stream (tdata, tstrb, tvalid, tready)
//   flush                 : marks the accepted beat as end of packet
//   m01_axis_t*           : downstream stream (tdata, tstrb, tvalid, tlast,
//                           tready)
//   pkt_count             : completed packets, wrapping
//   o_dbg_state           : framing FSM state (debug)
//   o_dbg_beat_cnt        : beat position within the packet (debug)
// Handshake: a beat moves on an edge where valid and ready are both high;
// valid never waits on ready, and an offered beat holds stable until taken.
// ---------------------------------------------------------------------------
module axis_packetizer
  import axis_packetizer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int PKT_LEN    = 16
) (
  input  logic                    s01_axis_aclk,
  input  logic                    s01_axis_aresetn,
  input  logic [DATA_WIDTH-1:0]   s01_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s01_axis_tstrb,
  input  logic                    s01_axis_tvalid,
  output logic                    s01_axis_tready,
  input  logic                    flush,
  output logic [DATA_WIDTH-1:0]   m01_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m01_axis_tstrb,
  output logic                    m01_axis_tvalid,
  output logic                    m01_axis_tlast,
  input  logic                    m01_axis_tready,
  output logic [PKT_CNT_W-1:0]    pkt_count,
  output logic                    o_dbg_state,
  output logic [15:0]             o_dbg_beat_cnt
);

  localparam int SW    = DATA_WIDTH / 8;
  localparam int FW    = DATA_WIDTH + SW + 1;
  localparam int CNT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

  state_t               r_state;
  logic [CNT_W-1:0]     r_beat_cnt;
  logic [PKT_CNT_W-1:0] r_pkt_count;

  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic [FW-1:0]         w_head;
  logic [DATA_WIDTH-1:0] w_head_data;
  logic [SW-1:0]         w_head_strb;
  logic                  w_head_flush;
  logic                  w_wr_en;
  logic                  w_out_xfer;
  logic                  w_last_beat;

  // Entry layout: {flush_flag, tstrb, tdata}.
  assign {w_head_flush, w_head_strb, w_head_data} = w_head;

  // Ready is forced low while reset is held so the upstream sees no window.
  assign s01_axis_tready = s01_axis_aresetn & ~w_fifo_full;
  // Zero-strobe beats are handshaken but never stored.
  assign w_wr_en = s01_axis_tvalid & s01_axis_tready & (|s01_axis_tstrb);

  axis_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (s01_axis_aclk),
    .i_rst_n   (s01_axis_aresetn),
    .i_wr_en   (w_wr_en),
    .i_wr_data ({flush, s01_axis_tstrb, s01_axis_tdata}),
    .i_rd_en   (m01_axis_tready),
    .o_rd_data (w_head),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty)
  );

  // Outputs are masked while empty so stale storage never shows after reset.
  assign m01_axis_tvalid = ~w_fifo_empty;
  assign m01_axis_tdata  = w_fifo_empty ? '0 : w_head_data;
  assign m01_axis_tstrb  = w_fifo_empty ? '0 : w_head_strb;
  assign w_last_beat     = (r_beat_cnt == CNT_W'(PKT_LEN - 1));
  assign m01_axis_tlast  = ~w_fifo_empty & (w_head_flush | w_last_beat);
  assign w_out_xfer      = m01_axis_tvalid & m01_axis_tready;

  always_ff @(posedge s01_axis_aclk or negedge s01_axis_aresetn) begin
    if (!s01_axis_aresetn) begin
      r_state     <= IDLE;
      r_beat_cnt  <= '0;
      r_pkt_count <= '0;
    end else if (w_out_xfer) begin
      if (m01_axis_tlast) begin
        r_state     <= IDLE;
        r_beat_cnt  <= '0;
        r_pkt_count <= r_pkt_count + PKT_CNT_W'(1);
      end else begin
        r_state    <= BODY;
        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
      end
    end
  end

  assign pkt_count      = r_pkt_count;
  assign o_dbg_state    = r_state;
  assign o_dbg_beat_cnt = 16'(r_beat_cnt);

endmodule

// File: tb/tb_axis_packetizer.sv
// ---------------------------------------------------------------------------
// tb_axis_packetizer
// Self-checking bench for axis_packetizer (DATA_WIDTH=32, FIFO_DEPTH=4,
// PKT_LEN=4). Inputs change 1 time unit after the rising edge; outputs are
// observed on the falling edge.
// ---------------------------------------------------------------------------
module tb_axis_packetizer;

  localparam int DW  = 32;
  localparam int SW  = DW / 8;
  localparam int PL  = 4;
  localparam int EW  = DW + SW + 1;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] s_tdata;
  logic [SW-1:0] s_tstrb;
  logic          s_tvalid;
  logic          s_tready;
  logic          s_flush;
  logic [DW-1:0] m_tdata;
  logic [SW-1:0] m_tstrb;
  logic          m_tvalid;
  logic          m_tlast;
  logic          m_tready;
  logic [15:0]   pkt_count;
  logic          dbg_state;
  logic [15:0]   dbg_beat_cnt;

  axis_packetizer #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (4),
    .PKT_LEN    (PL)
  ) dut (
    .s01_axis_aclk    (clk),
    .s01_axis_aresetn (rst_n),
    .s01_axis_tdata   (s_tdata),
    .s01_axis_tstrb   (s_tstrb),
    .s01_axis_tvalid  (s_tvalid),
    .s01_axis_tready  (s_tready),
    .flush            (s_flush),
    .m01_axis_tdata   (m_tdata),
    .m01_axis_tstrb   (m_tstrb),
    .m01_axis_tvalid  (m_tvalid),
    .m01_axis_tlast   (m_tlast),
    .m01_axis_tready  (m_tready),
    .pkt_count        (pkt_count),
    .o_dbg_state      (dbg_state),
    .o_dbg_beat_cnt   (dbg_beat_cnt)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  int n_out  = 0;
  int mdl_cnt = 0;
  logic [EW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Output monitor: pops the expected beat on each downstream transfer,
  // models tlast from an independent beat counter, checks stall stability,
  // then records any beat that will be accepted on the coming edge.
  initial begin
    logic [EW-1:0] e;
    logic          exp_last;
    logic          prev_stall;
    logic [EW-1:0] prev_out;
    prev_stall = 1'b0;
    prev_out   = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && m_tvalid)
          chk("stall_stable", {m_tlast, m_tstrb, m_tdata}, prev_out);
        prev_stall = m_tvalid && !m_tready;
        prev_out   = {m_tlast, m_tstrb, m_tdata};
        if (m_tvalid && m_tready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", {m_tstrb, m_tdata}, 64'hDEAD_0000_0000);
          end else begin
            e = exp_q.pop_front();
            exp_last = e[EW-1] || (mdl_cnt == PL - 1);
            chk("out_beat", {m_tstrb, m_tdata}, e[EW-2:0]);
            chk("out_tlast", m_tlast, exp_last);
            mdl_cnt = exp_last ? 0 : mdl_cnt + 1;
            n_out++;
          end
        end
        if (s_tvalid && s_tready && s_tstrb != '0)
          exp_q.push_back({s_flush, s_tstrb, s_tdata});
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks start and return 1 time unit after a rising edge.
  task automatic send_beat(input logic [DW-1:0] d, input logic [SW-1:0] s, input logic f);
    bit acc;
    int n;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tstrb  = s;
    s_flush  = f;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = s_tready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: beat 0x%0h not accepted within 200 cycles", d);
    end
  endtask

  task automatic go_idle();
    s_tvalid = 1'b0;
    s_flush  = 1'b0;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_tvalid) && n < 5000) begin
      step(1);
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  task automatic plain_reset();
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    mdl_cnt = 0;
    n_out   = 0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic          flush;
    logic          exp_last;
    logic [15:0]   exp_pkt;
    logic [15:0]   exp_cnt;
  } vec_t;

  vec_t vecs[21];

  function automatic vec_t mk(input logic [DW-1:0] d, input logic [SW-1:0] s, input logic f,
                              input logic l, input logic [15:0] p, input logic [15:0] c);
    vec_t v;
    v.data = d; v.strb = s; v.flush = f; v.exp_last = l; v.exp_pkt = p; v.exp_cnt = c;
    return v;
  endfunction

  bit rand_done;

  initial begin
    vecs[0]  = mk(32'h1,  4'hF, 1'b0, 1'b0, 16'd0, 16'd1);
    vecs[1]  = mk(32'h2,  4'hF, 1'b0, 1'b0, 16'd0, 16'd2);
    vecs[2]  = mk(32'h3,  4'hF, 1'b0, 1'b0, 16'd0, 16'd3);
    vecs[3]  = mk(32'h4,  4'hF, 1'b0, 1'b1, 16'd1, 16'd0);
    vecs[4]  = mk(32'h5,  4'hF, 1'b0, 1'b0, 16'd1, 16'd1);
    vecs[5]  = mk(32'h6,  4'hF, 1'b0, 1'b0, 16'd1, 16'd2);
    vecs[6]  = mk(32'h7,  4'hF, 1'b0, 1'b0, 16'd1, 16'd3);
    vecs[7]  = mk(32'h8,  4'hF, 1'b0, 1'b1, 16'd2, 16'd0);
    vecs[8]  = mk(32'hA,  4'hF, 1'b0, 1'b0, 16'd2, 16'd1);
    vecs[9]  = mk(32'hB,  4'hF, 1'b0, 1'b0, 16'd2, 16'd2);
    vecs[10] = mk(32'hC,  4'hF, 1'b1, 1'b1, 16'd3, 16'd0);
    vecs[11] = mk(32'h31, 4'hF, 1'b0, 1'b0, 16'd3, 16'd1);
    vecs[12] = mk(32'h32, 4'hF, 1'b0, 1'b0, 16'd3, 16'd2);
    vecs[13] = mk(32'h33, 4'hF, 1'b0, 1'b0, 16'd3, 16'd3);
    vecs[14] = mk(32'h34, 4'hF, 1'b0, 1'b1, 16'd4, 16'd0);
    vecs[15] = mk(32'h11, 4'h0, 1'b0, 1'b0, 16'd4, 16'd0);
    vecs[16] = mk(32'h22, 4'hF, 1'b0, 1'b0, 16'd4, 16'd1);
    vecs[17] = mk(32'h55, 4'h0, 1'b1, 1'b0, 16'd4, 16'd1);
    vecs[18] = mk(32'h66, 4'h3, 1'b0, 1'b0, 16'd4, 16'd2);
    vecs[19] = mk(32'h77, 4'hF, 1'b0, 1'b0, 16'd4, 16'd3);
    vecs[20] = mk(32'h88, 4'hF, 1'b0, 1'b1, 16'd5, 16'd0);

    rst_n     = 1'b0;
    s_tvalid  = 1'b0;
    s_tdata   = '0;
    s_tstrb   = '0;
    s_flush   = 1'b0;
    m_tready  = 1'b1;
    rand_done = 1'b0;

    // Reset state while held.
    #2;
    chk("rst_s_tready", s_tready, 0);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_pkt_count", pkt_count, 0);
    chk("rst_state", dbg_state, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_s_tready", s_tready, 1);
    chk("post_rst_m_tvalid", m_tvalid, 0);

    // Table: one beat at a time, downstream always ready.
    for (int i = 0; i < 21; i++) begin
      send_beat(vecs[i].data, vecs[i].strb, vecs[i].flush);
      go_idle();
      if (vecs[i].strb != '0) begin
        chk("tbl_tvalid", m_tvalid, 1);
        chk("tbl_tdata", m_tdata, vecs[i].data);
        chk("tbl_tstrb", m_tstrb, vecs[i].strb);
        chk("tbl_tlast", m_tlast, vecs[i].exp_last);
      end else begin
        chk("tbl_dropped", m_tvalid, 0);
      end
      step(1);
      chk("tbl_pkt_count", pkt_count, vecs[i].exp_pkt);
      chk("tbl_beat_cnt", dbg_beat_cnt, vecs[i].exp_cnt);
    end

    // Back-pressure: fill the FIFO with downstream stalled.
    m_tready = 1'b0;
    for (int i = 1; i <= 4; i++) send_beat(DW'(i), 4'hF, 1'b0);
    chk("full_s_tready", s_tready, 0);
    s_tdata = 32'h5;
    for (int i = 0; i < 3; i++) begin
      chk("stall_head", m_tdata, 32'h1);
      step(1);
    end
    chk("still_full", s_tready, 0);
    m_tready = 1'b1;
    send_beat(32'h5, 4'hF, 1'b0);
    go_idle();
    wait_drain();
    chk("bp_beat_cnt", dbg_beat_cnt, 1);
    chk("bp_state", dbg_state, 1);
    chk("bp_pkt_count", pkt_count, 6);

    // Reset with beats buffered and upstream valid.
    m_tready = 1'b0;
    for (int i = 0; i < 3; i++) send_beat(32'h41 + DW'(i), 4'hF, 1'b0);
    s_tdata = 32'h44;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_m_tvalid", m_tvalid, 0);
    chk("mid_rst_m_tdata", m_tdata, 0);
    chk("mid_rst_m_tlast", m_tlast, 0);
    chk("mid_rst_s_tready", s_tready, 0);
    chk("mid_rst_pkt_count", pkt_count, 0);
    chk("mid_rst_beat_cnt", dbg_beat_cnt, 0);
    exp_q.delete();
    mdl_cnt  = 0;
    n_out    = 0;
    s_tdata  = 32'h99;
    m_tready = 1'b1;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    chk("rel_s_tready", s_tready, 1);
    chk("rel_m_tvalid", m_tvalid, 0);
    @(posedge clk);
    #1;
    go_idle();
    chk("first_after_rst_valid", m_tvalid, 1);
    chk("first_after_rst_data", m_tdata, 32'h99);
    wait_drain();
    chk("first_after_rst_out", n_out, 1);

    // Random downstream back-pressure over 1000 beats.
    plain_reset();
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          send_beat($urandom, 4'hF, 1'b0);
          if ($urandom_range(0, 7) == 0) begin
            go_idle();
            step($urandom_range(1, 3));
          end
        end
        go_idle();
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          m_tready = ($urandom_range(0, 1) == 1);
        end
      end
    join
    m_tready = 1'b1;
    wait_drain();
    chk("rand_out_beats", n_out, 1000);
    chk("rand_pkt_count", pkt_count, 1000 / PL);
    chk("rand_state", dbg_state, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_packetizer.md
AXIS_PACKETIZER -- requirements
Module: axis_packetizer

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of the stream data in bits.
REQ-002 Parameter FIFO_DEPTH, default 4 (power of two, at least 2): number of buffered beats.
REQ-003 Parameter PKT_LEN, default 16 (at least 1): beats per full packet.
REQ-004 Port s01_axis_aclk, input, 1 bit: the single clock for all logic.
REQ-005 Port s01_axis_aresetn, input, 1 bit: reset, asynchronous, active-low.
REQ-006 Port s01_axis_tdata, input, DATA_WIDTH bits: upstream data.
REQ-007 Port s01_axis_tstrb, input, DATA_WIDTH/8 bits: upstream byte strobes.
REQ-008 Port s01_axis_tvalid, input, 1 bit: upstream beat valid.
REQ-009 Port s01_axis_tready, output, 1 bit: block can accept a beat.
REQ-010 Port flush, input, 1 bit: sampled with an accepted beat; marks that beat as packet end.
REQ-011 Port m01_axis_tdata, output, DATA_WIDTH bits: downstream data, feeding the memory write port.
REQ-012 Port m01_axis_tstrb, output, DATA_WIDTH/8 bits: downstream strobes.
REQ-013 Port m01_axis_tvalid, output, 1 bit: downstream beat valid.
REQ-014 Port m01_axis_tlast, output, 1 bit: last beat of a packet.
REQ-015 Port m01_axis_tready, input, 1 bit: downstream accepts the beat.
REQ-016 Port pkt_count, output, 16 bits: number of completed packets, wrapping.

Function
REQ-017 Input transfer occurs when s01_axis_tvalid and s01_axis_tready are both high on a clock edge.
- Output transfer occurs when m01_axis_tvalid and m01_axis_tready are both high on a clock edge.
REQ-018 s01_axis_tready SHALL be high exactly when FIFO occupancy is below FIFO_DEPTH (combinational from occupancy).
- When full, no write occurs, even if a pop happens in the same cycle.
REQ-019 An accepted beat with tstrb equal to zero SHALL be consumed and discarded.
- It is not stored, it does not advance the beat counter, and its flush is ignored.
REQ-020 Each stored entry SHALL hold tdata, tstrb and flush_flag.
- Beats leave the FIFO in arrival order.
REQ-021 Latency: a beat written at edge N SHALL be presented on m01 (tvalid high) from edge N+1 onward.
REQ-022 m01_axis_tvalid SHALL equal FIFO non-empty.
- While tvalid is high and tready is low, tdata, tstrb and tlast SHALL hold stable.
REQ-023 A simultaneous push and pop at occupancy between 1 and FIFO_DEPTH-1 SHALL leave occupancy unchanged.
- A push and pop at occupancy 0 is impossible, since tvalid is low at that occupancy.
REQ-024 FSM with states IDLE and BODY:
- IDLE means no beat of the current packet has been sent; BODY means at least one has.
- IDLE to BODY on an output transfer with tlast low.
- BODY to IDLE on an output transfer with tlast high.
- IDLE stays IDLE on a tlast-high transfer (single-beat packet).
REQ-025 The beat counter SHALL count from 0 to PKT_LEN-1.
- It increments on each output transfer with tlast low.
- It returns to 0 on each output transfer with tlast high.
REQ-026 m01_axis_tlast SHALL be high when the head entry's flush_flag is set, or when the beat counter equals PKT_LEN-1.
REQ-027 pkt_count SHALL increment by 1 on each output transfer with tlast high, wrapping from 0xFFFF to 0.
REQ-028 Pointers SHALL wrap modulo FIFO_DEPTH.
- Occupancy is tracked with a counter one bit wider than the pointers.

Reset
REQ-029 Asserting s01_axis_aresetn low SHALL immediately clear the following, at any point mid-operation:
- FIFO pointers and occupancy;
- beat counter, pkt_count and FSM (to IDLE);
- m01_axis_tvalid, m01_axis_tlast, m01_axis_tdata, m01_axis_tstrb and s01_axis_tready, all to 0.
- Buffered beats are lost.
REQ-030 On the first edge after deassertion, s01_axis_tready SHALL be 1 and m01_axis_tvalid SHALL be 0.

Structure
REQ-031 The shared package SHALL hold the FSM state encoding (IDLE=0, BODY=1) and the pkt_count width constant (16).
REQ-032 The FIFO storage and pointers SHALL be one sub-module, axis_sync_fifo.
- It is parameterized by width (DATA_WIDTH + DATA_WIDTH/8 + 1) and FIFO_DEPTH.
- Framing logic stays in the top module.

Verification
REQ-033 Use PKT_LEN=4 and m01_axis_tready held at 1; send 8 beats 0x1..0x8 with tstrb=0xF.
- Required: tlast high on the beats carrying 0x4 and 0x8, and pkt_count ends at 2.
REQ-034 Hold m01_axis_tready at 0 and send 5 beats.
- Required: s01_axis_tready drops after the 4th beat, and output 0x1 stays stable.
- Required: after tready is raised, the output order is 0x1..0x4 with no loss.
REQ-035 Send 0xA, 0xB, then 0xC with flush=1.
- Required: tlast is high on 0xC, the counter restarts, and the next 4 beats end with tlast on the 4th.
REQ-036 Send 0x11 with tstrb=0, then 0x22 with tstrb=0xF.
- Required: only 0x22 appears on the output, and the beat counter equals 1 afterward.
REQ-037 Assert reset with 3 beats buffered and tvalid high.
- Required: tvalid goes to 0 without waiting for a clock edge, and pkt_count reads 0.
- Required: the first beat after reset is output on the next edge.
REQ-038 Toggle m01_axis_tready at random for 1000 beats with a scoreboard attached.
- Required: data order matches input, tlast falls every PKT_LEN beats, and pkt_count = 1000/PKT_LEN.
